// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer geometry constants and pixel writer state type
package fb_pkg;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int COLOUR_W  = 3;
  localparam int ADDR_W    = 15;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR
  } fb_state_e;
endpackage

// File: rtl/pixel_fb_writer_if.sv
// rtl/pixel_fb_writer_if.sv - pixel beat stream in, frame-buffer write port out
interface pixel_fb_writer_if;
  import fb_pkg::*;

  logic                plot_in;
  logic [7:0]          x_in;
  logic [6:0]          y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                ready_out;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_grant;

  // master: pixel producer plus frame-buffer RAM; slave: the writer itself
  modport master (
    output plot_in, x_in, y_in, colour_in, fb_grant,
    input  ready_out, fb_we, fb_addr, fb_data
  );
  modport slave (
    input  plot_in, x_in, y_in, colour_in, fb_grant,
    output ready_out, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO with full/empty/last-entry flags
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q, count;
  logic             do_push, do_pop;

  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign count   = wptr_q - rptr_q;
  assign full_o  = count == (AW+1)'(DEPTH);
  assign empty_o = count == '0;
  assign last_o  = count == (AW+1)'(1);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - buffers pixel beats and writes them, or a full-screen clear, into the frame buffer
// Optional transparent-colour skip: PIXEL_FB_WRITER_TRANSPARENT_KEY_EN
module pixel_fb_writer
  import fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int FIFO_DEPTH = 4
`ifdef PIXEL_FB_WRITER_TRANSPARENT_KEY_EN
  , parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
`endif
) (
  input  logic                clk,
  input  logic                reset,
  pixel_fb_writer_if.slave    bus,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_done,
  output logic                idle,
  output logic [15:0]         drop_count,
  output logic [15:0]         write_count
);
  localparam int ENTRY_W = ADDR_W + COLOUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  fb_state_e           state_q, state_d;
  logic [COLOUR_W-1:0] clr_colour_q;
  logic [ADDR_W-1:0]   sweep_q;
  logic                clear_done_q;
  logic [15:0]         drop_q, wr_q;

  logic                ready, accept, in_range, key_hit, push, pop, granted, sweep_last;
  logic                fifo_full, fifo_empty, fifo_last;
  logic [ADDR_W-1:0]   beat_addr;
  logic [ENTRY_W-1:0]  head;

  assign accept     = bus.plot_in && ready;
  assign in_range   = (32'(bus.x_in) < WIDTH) && (32'(bus.y_in) < HEIGHT);
`ifdef PIXEL_FB_WRITER_TRANSPARENT_KEY_EN
  assign key_hit    = bus.colour_in == KEY_COLOUR;
`else
  assign key_hit    = 1'b0;
`endif
  assign beat_addr  = ADDR_W'(bus.x_in) + ADDR_W'(WIDTH) * ADDR_W'(bus.y_in);
  assign push       = accept && in_range && !key_hit;
  assign granted    = bus.fb_we && bus.fb_grant;
  assign pop        = granted && (state_q != ST_CLEAR);
  assign sweep_last = sweep_q == LAST_ADDR;

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({beat_addr, bus.colour_in}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .last_o      (fifo_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // the pop that empties the FIFO may hand over to the sweep directly
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (clear_req) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || (pop && fifo_last)) state_d = ST_CLEAR;
      ST_CLEAR: if (granted && sweep_last) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_RUN) && !fifo_full;
    idle  = (state_q == ST_RUN) && fifo_empty;
    if (state_q == ST_CLEAR) begin
      bus.fb_we   = 1'b1;
      bus.fb_addr = sweep_q;
      bus.fb_data = clr_colour_q;
    end else begin
      bus.fb_we   = !fifo_empty;
      bus.fb_addr = fifo_empty ? '0 : head[ENTRY_W-1:COLOUR_W];
      bus.fb_data = fifo_empty ? '0 : head[COLOUR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_colour_q <= '0;
      sweep_q      <= '0;
      clear_done_q <= 1'b0;
      drop_q       <= '0;
      wr_q         <= '0;
    end else begin
      clear_done_q <= (state_q == ST_CLEAR) && granted && sweep_last;
      if (state_q == ST_RUN && clear_req) begin
        clr_colour_q <= clear_colour;
        sweep_q      <= '0;
      end else if (state_q == ST_CLEAR && granted) begin
        sweep_q <= sweep_q + 1'b1;
      end
      if (accept && !in_range && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (granted) wr_q <= wr_q + 16'd1;
    end
  end

  assign bus.ready_out = ready;
  assign clear_done    = clear_done_q;
  assign drop_count    = drop_q;
  assign write_count   = wr_q;
endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb/tb_pixel_fb_writer.sv - randomized bench for pixel_fb_writer against a queue-based reference model
module tb_pixel_fb_writer;
  import fb_pkg::*;

  localparam int DEPTH       = 4;
  localparam int CLEAR_BOUND = 2 * FB_PIXELS + 200;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                clear_req = 1'b0;
  logic [COLOUR_W-1:0] clear_colour = '0;
  logic                clear_done, idle;
  logic [15:0]         drop_count, write_count;

  pixel_fb_writer_if bus();

  pixel_fb_writer dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .idle         (idle),
    .drop_count   (drop_count),
    .write_count  (write_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: pending beat writes in order, plus an implicit clear sweep
  int exp_addr_q[$];
  int exp_data_q[$];
  bit m_clearing, m_done_next;
  int m_clear_idx, m_clear_col, m_drops, m_writes, m_bubbles;
  bit last_accept;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_key(input int col);
`ifdef PIXEL_FB_WRITER_TRANSPARENT_KEY_EN
    return col == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    exp_addr_q.delete();
    exp_data_q.delete();
    m_clearing  = 1'b0;
    m_done_next = 1'b0;
    m_clear_idx = 0;
    m_drops     = 0;
    m_writes    = 0;
    m_bubbles   = 0;
  endtask

  task automatic step(input bit plot, input int x, input int y, input int col,
                      input bit grant, input bit creq, input int ccol);
    bit m_ready, was_clearing;
    int nb;
    @(negedge clk);
    bus.plot_in   = plot;
    bus.x_in      = 8'(x);
    bus.y_in      = 7'(y);
    bus.colour_in = COLOUR_W'(col);
    bus.fb_grant  = grant;
    clear_req     = creq;
    clear_colour  = COLOUR_W'(ccol);
    #1;
    nb      = exp_addr_q.size();
    m_ready = !m_clearing && nb < DEPTH;
    last_accept = plot && bus.ready_out;
    check_eq("ready_out", bus.ready_out, m_ready);
    check_eq("idle", idle, !m_clearing && nb == 0);
    check_eq("clear_done", clear_done, m_done_next);
    check_eq("drop_count", drop_count, m_drops);
    check_eq("write_count", write_count, m_writes);
    if (!m_clearing || nb > 0) check_eq("fb_we", bus.fb_we, nb > 0);
    if (bus.fb_we && nb > 0) begin
      check_eq("fb_addr", bus.fb_addr, exp_addr_q[0]);
      check_eq("fb_data", bus.fb_data, exp_data_q[0]);
    end else if (bus.fb_we && m_clearing) begin
      check_eq("clear_addr", bus.fb_addr, m_clear_idx);
      check_eq("clear_data", bus.fb_data, m_clear_col);
    end else if (m_clearing && nb == 0) begin
      m_bubbles++;
    end

    was_clearing = m_clearing;
    m_done_next  = 1'b0;
    if (bus.fb_we && grant) begin
      if (nb > 0) begin
        void'(exp_addr_q.pop_front());
        void'(exp_data_q.pop_front());
        m_writes = (m_writes + 1) & 16'hFFFF;
      end else if (m_clearing) begin
        m_clear_idx++;
        m_writes = (m_writes + 1) & 16'hFFFF;
        if (m_clear_idx == FB_PIXELS) begin
          m_clearing  = 1'b0;
          m_done_next = 1'b1;
          check_eq("clear_bubbles", m_bubbles <= 1, 1);
        end
      end
    end
    if (plot && m_ready) begin
      if (x < FB_WIDTH && y < FB_HEIGHT) begin
        if (!is_key(col)) begin
          exp_addr_q.push_back(x + FB_WIDTH * y);
          exp_data_q.push_back(col);
        end
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
    if (creq && !was_clearing) begin
      m_clearing  = 1'b1;
      m_clear_idx = 0;
      m_clear_col = ccol;
      m_bubbles   = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.plot_in  = 1'b0;
    bus.fb_grant = 1'b0;
    clear_req    = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_fb_we", bus.fb_we, 0);
    check_eq("rst_ready", bus.ready_out, 1);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_fb_addr", bus.fb_addr, 0);
    check_eq("rst_fb_data", bus.fb_data, 0);
    check_eq("rst_clear_done", clear_done, 0);
    check_eq("rst_drop_count", drop_count, 0);
    check_eq("rst_write_count", write_count, 0);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_addr_q.size() > 0; i++) step(0, 0, 0, 0, 1, 0, 0);
    check_eq("drain_timeout", exp_addr_q.size(), 0);
  endtask

  initial begin
    int burst_acc;
    bus.plot_in   = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.colour_in = '0;
    bus.fb_grant  = 1'b0;
    model_reset();
    do_reset();

    step(1, 3, 2, 5, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("single_write_count", write_count, 1);

    burst_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 20 + i, 5, i + 1, 0, 0, 0);
      burst_acc += int'(last_accept);
    end
    check_eq("burst_accepted", burst_acc, 4);
    drain(50);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("burst_write_count", write_count, 5);

    step(1, 160, 0, 2, 1, 0, 0);
    step(1, 0, 120, 2, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("range_drops", drop_count, 2);
    check_eq("range_ready", bus.ready_out, 1);

    step(1, 7, 7, 1, 0, 0, 0);
    step(1, 8, 7, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 3);
    for (int i = 0; i < CLEAR_BOUND && m_clearing; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 170), $urandom_range(0, 127),
           $urandom_range(0, 7), 1, $urandom_range(0, 63) == 0, $urandom_range(0, 7));
    check_eq("clear_timeout", m_clearing, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check_eq("clear_done_pulse", clear_done, 1);
    check_eq("clear_idle", idle, 1);
    step(0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 175), $urandom_range(0, 127),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0, 0, 0);
    drain(100);

    step(0, 0, 0, 0, 1, 1, 6);
    for (int i = 0; i < 3000 && m_clearing && m_clear_idx < 500; i++)
      step(0, 0, 0, 0, $urandom_range(0, 1), 0, 0);
    check_eq("sweep_reached_500", m_clear_idx, 500);
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0);

    step(1, 10, 10, 0, 1, 0, 0);
    step(1, 11, 10, 4, 1, 0, 0);
    drain(20);
    step(0, 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
